ntt_stream_ctrl: RTL and testbench
==================================

Name: ntt_stream_ctrl

Overview:
- Sequencer that wraps the parallel N-point NTT butterfly network behind streaming valid/ready interfaces.
- Collects N coefficients one per beat into a load buffer, then drives the whole vector plus mode into the NTT datapath.
- Waits the datapath's fixed pipeline latency, captures the result vector, and streams it out one coefficient per beat.
- Sits between the polynomial memory/DMA and the NTT core; processes one polynomial at a time.

Parameters:
- W, 16, coefficient width.
- N, 8, NTT points (power of 2, >=2).
- Modulus_Q, 12289, NTT modulus.
- PIPE_LAT, 3, register stages through the NTT datapath (0 = combinational).
- N_INV, 10753, N^-1 mod Modulus_Q (used only by the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  controller can accept an input beat.
- in_data  in  W  coefficient, natural order, index 0 first.
- in_inv  in  1  inverse-NTT request; sampled on beat 0 only.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the output beat.
- out_data  out  W  result coefficient, index 0 first.
- out_last  out  1  high with beat N-1.
- ntt_data_o  out  [W-1:0] x [0:N-1]  vector driven to NTT Data_in.
- ntt_inv_o  out  1  drives NTT iNTT_mode.
- ntt_data_i  in  [W-1:0] x [0:N-1]  NTT Data_out.
- busy  out  1  high in any state other than LOAD with count 0.
- range_err  out  1  sticky flag: some accepted in_data >= Modulus_Q.

Behaviour:
- Reset: state=LOAD, counters=0. in_ready=1, out_valid=0, out_last=0, out_data=0, ntt_data_o all 0, ntt_inv_o=0, busy=0, range_err=0.
- Reset mid-operation aborts the current frame. Partial load and unload data are discarded.
- Input handshake: a beat transfers on in_valid & in_ready. Output handshake: a beat transfers on out_valid & out_ready.
- LOAD:
  - in_ready=1. Accepted beat k is written to buffer[k]; count increments.
  - Beat 0 latches in_inv into a mode register.
  - Beat N-1 moves the state to COMPUTE next cycle and clears count.
  - If the beat's in_data >= Modulus_Q, set range_err. The value is stored unmodified.
- COMPUTE:
  - in_ready=0. ntt_data_o and ntt_inv_o are driven from the buffer and mode register; they stay stable for the whole state.
  - The state lasts exactly PIPE_LAT+1 cycles.
  - On the final cycle, ntt_data_i is captured into the output buffer and the state moves to UNLOAD.
- UNLOAD:
  - out_valid=1, out_data=obuf[idx], out_last=(idx==N-1).
  - Data is held stable while out_ready=0.
  - On transfer idx increments. The beat-N-1 transfer returns the state to LOAD with in_ready=1 the next cycle.
- ntt_data_o keeps its last value outside COMPUTE.
- range_err clears only on reset.
- Latency: N-th input accepted at cycle t gives first out_valid at t+PIPE_LAT+2. For the defaults, that is t+5.
- No overlap: input is not accepted during COMPUTE or UNLOAD. Throughput is one frame per N+PIPE_LAT+1+N cycles, minimum.
- in_inv on beats 1..N-1 is ignored.

Optional Feature:
- Macro NTT_CTRL_INV_SCALE_EN.
- Defined:
  - In inverse mode, each captured coefficient is multiplied by N_INV mod Modulus_Q at capture.
  - Arithmetic uses a 2W-bit product followed by a modulo reduction.
  - Forward mode results are passed unchanged.
  - The scaling is fully inside the capture cycle, so latency is unchanged.
- Undefined: results are passed unscaled in both modes, and N_INV is unused.

Test Plan:
- Impulse forward, defaults: in=[1,0,0,0,0,0,0,0], in_inv=0, out_ready=1 -> 8 outputs all 1; out_last on beat 8; first out_valid exactly 5 cycles after the 8th input beat.
- All-ones forward: in=[1]*8 -> outputs [8,0,0,0,0,0,0,0]; busy low again the cycle after the last output.
- Inverse with scaling (macro defined): in=[8,0,...,0], in_inv=1 -> all outputs 1, since 8*10753 mod 12289 = 1. Without the macro the same stimulus -> all outputs 8.
- Backpressure: out_ready toggles 1,0,0,1,... during UNLOAD -> out_data/out_last held stable while stalled; no beat dropped or duplicated; in_ready=0 throughout COMPUTE and UNLOAD.
- Range/gaps: inputs with gaps in in_valid and beat 3 = 12289 -> range_err rises the cycle after beat 3 and stays high; the frame still completes and output count = 8.
- Reset mid-UNLOAD after 3 output beats: reset for 1 cycle -> next cycle out_valid=0, in_ready=1, range_err=0; a new impulse frame then produces 8 ones.

Source files
------------

// File: rtl/ntt_stream_ctrl.sv
// Streaming valid/ready sequencer around a parallel N-point NTT datapath.
// Optional macro NTT_CTRL_INV_SCALE_EN scales inverse-mode results by N_INV at capture.
//
// state   | meaning
// LOAD    | accept N input beats into the load buffer
// COMPUTE | hold vector/mode on the NTT datapath for PIPE_LAT+1 cycles, capture on last
// UNLOAD  | stream the captured result vector, one coefficient per beat
module ntt_stream_ctrl #(
  parameter int W         = 16,
  parameter int N         = 8,
  parameter int Modulus_Q = 12289,
  parameter int PIPE_LAT  = 3,
  parameter int N_INV     = 10753
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [W-1:0] ntt_data_o [0:N-1],
  output logic         ntt_inv_o,
  input  logic [W-1:0] ntt_data_i [0:N-1],
  output logic         busy,
  output logic         range_err
);

  localparam int CNT_W = $clog2(N);
  localparam int LAT_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(PIPE_LAT);
  localparam logic [31:0]      Q_U      = 32'(Modulus_Q);

  if (N < 2 || N_INV >= Modulus_Q) begin : g_bad_param
    $error("ntt_stream_ctrl: N must be >= 2 and N_INV must be reduced mod Modulus_Q");
  end

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       load_buf [0:N-1];
  logic [W-1:0]       obuf     [0:N-1];
  logic [W-1:0]       scaled   [0:N-1];
  logic [CNT_W-1:0]   count, idx;
  logic [LAT_W-1:0]   lat_cnt;
  logic               mode_q;
  logic               in_fire, out_fire, load_done, unload_done;

  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign load_done   = in_fire && (count == LAST_IDX);
  assign unload_done = out_fire && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_done) state_nxt = COMPUTE;
      COMPUTE: if (lat_cnt == '0) state_nxt = UNLOAD;
      UNLOAD:  if (unload_done) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == UNLOAD);
    out_data  = out_valid ? obuf[idx] : '0;
    out_last  = out_valid && (idx == LAST_IDX);
    busy      = !((state == LOAD) && (count == '0));
  end

`ifdef NTT_CTRL_INV_SCALE_EN
  localparam int          PW      = 2 * W;
  localparam logic [PW-1:0] N_INV_P = PW'(N_INV);
  localparam logic [PW-1:0] Q_P     = PW'(Modulus_Q);

  // Reduction stays inside the capture cycle so the frame latency is unchanged.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      scaled[i] = ntt_inv_o ? W'(({{W{1'b0}}, ntt_data_i[i]} * N_INV_P) % Q_P)
                            : ntt_data_i[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N; i++) scaled[i] = ntt_data_i[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      idx       <= '0;
      lat_cnt   <= '0;
      mode_q    <= 1'b0;
      ntt_inv_o <= 1'b0;
      range_err <= 1'b0;
      for (int i = 0; i < N; i++) begin
        load_buf[i]   <= '0;
        obuf[i]       <= '0;
        ntt_data_o[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        load_buf[count] <= in_data;
        if (count == '0) mode_q <= in_inv;
        if (32'(in_data) >= Q_U) range_err <= 1'b1;
        if (count == LAST_IDX) begin
          // The datapath vector is frozen here so it only changes when a new frame starts.
          count   <= '0;
          lat_cnt <= LAT_INIT;
          for (int i = 0; i < N - 1; i++) ntt_data_o[i] <= load_buf[i];
          ntt_data_o[N-1] <= in_data;
          ntt_inv_o       <= mode_q;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
      if (state == COMPUTE) begin
        if (lat_cnt == '0) begin
          for (int i = 0; i < N; i++) obuf[i] <= scaled[i];
          idx <= '0;
        end else begin
          lat_cnt <= lat_cnt - LAT_W'(1);
        end
      end
      if (out_fire) idx <= (idx == LAST_IDX) ? '0 : idx + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// Self-checking bench for ntt_stream_ctrl with a behavioural NTT core and reference model.
module tb_ntt_stream_ctrl;
  localparam int W = 16, N = 8, Q = 12289, PIPE_LAT = 3, N_INV = 10753;
  typedef logic [W-1:0] vec_t [0:N-1];

  logic clk = 1'b0;
  logic reset = 1'b1, in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, ntt_inv_o, busy, range_err;
  logic [W-1:0] out_data;
  vec_t ntt_data_o, ntt_data_i;
  vec_t pipe [0:PIPE_LAT-1];

  int n_tests = 0, n_fail = 0, cyc = 0;
  longint omega, omega_inv;

  ntt_stream_ctrl #(.W(W), .N(N), .Modulus_Q(Q), .PIPE_LAT(PIPE_LAT), .N_INV(N_INV)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .ntt_data_o(ntt_data_o), .ntt_inv_o(ntt_inv_o),
    .ntt_data_i(ntt_data_i), .busy(busy), .range_err(range_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint mpow(longint b, longint e);
    longint r = 1;
    b = b % Q;
    while (e > 0) begin
      if (e[0]) r = (r * b) % Q;
      b = (b * b) % Q;
      e = e >> 1;
    end
    return r;
  endfunction

  // Direct O(N^2) transform: X[k] = sum_j x[j] * w^(j*k) mod Q.
  function automatic vec_t ntt_ref(vec_t x, bit inv);
    vec_t y;
    longint w = inv ? omega_inv : omega;
    for (int k = 0; k < N; k++) begin
      longint acc = 0;
      for (int j = 0; j < N; j++)
        acc = (acc + (longint'(x[j]) % Q) * mpow(w, longint'(j * k))) % Q;
      y[k] = W'(acc);
    end
    return y;
  endfunction

  function automatic vec_t expect_out(vec_t x, bit inv);
    vec_t y = ntt_ref(x, inv);
`ifdef NTT_CTRL_INV_SCALE_EN
    if (inv) for (int k = 0; k < N; k++) y[k] = W'((longint'(y[k]) * N_INV) % Q);
`endif
    return y;
  endfunction

  // Behavioural NTT core: PIPE_LAT register stages after a combinational transform.
  always @(posedge clk) begin
    pipe[0] <= ntt_ref(ntt_data_o, ntt_inv_o);
    for (int s = 1; s < PIPE_LAT; s++) pipe[s] <= pipe[s-1];
  end
  always_comb ntt_data_i = pipe[PIPE_LAT-1];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_frame(input vec_t x, input bit inv, input bit gaps, input bit junk_inv,
                            output int acc_cyc, output bit [N-1:0] re_after);
    for (int k = 0; k < N; k++) begin
      int guard = 0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = x[k];
      in_inv   = (k == 0) ? inv : (junk_inv ? 1'($urandom) : 1'b0);
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      acc_cyc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      in_inv   = 1'b0;
      re_after[k] = range_err;
    end
  endtask

  task automatic collect_frame(input int stall_mode, output vec_t y, output bit [N-1:0] lasts,
                               output int first_cyc, output int stab_bad, output int rdy_bad,
                               output vec_t snap, output bit snap_inv, output bit timeout);
    int beats = 0, budget = 0, pat = 0;
    bit stalled = 0, r;
    logic [W-1:0] prev_d = '0;
    logic prev_l = 1'b0;
    first_cyc = -1; stab_bad = 0; rdy_bad = 0; lasts = '0;
    snap = ntt_data_o; snap_inv = ntt_inv_o;
    for (int k = 0; k < N; k++) y[k] = '0;
    while (beats < N && budget < 400) begin
      if (in_ready) rdy_bad++;
      for (int k = 0; k < N; k++) if (ntt_data_o[k] !== snap[k]) stab_bad++;
      if (!out_valid) begin
        out_ready = 1'($urandom);
        @(negedge clk);
        budget++;
        continue;
      end
      if (first_cyc < 0) first_cyc = cyc;
      if (stalled && (out_data !== prev_d || out_last !== prev_l)) stab_bad++;
      case (stall_mode)
        0: r = 1'b1;
        1: r = (pat % 3 == 0);
        default: r = 1'($urandom);
      endcase
      pat++;
      out_ready = r;
      if (r) begin
        y[beats] = out_data;
        lasts[beats] = out_last;
        beats++;
      end
      stalled = !r;
      prev_d = out_data;
      prev_l = out_last;
      @(negedge clk);
      budget++;
    end
    out_ready = 1'b0;
    timeout = (beats < N);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    n_tests++; if (ntt_inv_o !== 1'b0) begin n_fail++; $display("FAIL reset_ntt_inv got %b want 0", ntt_inv_o); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL reset_range_err got %b want 0", range_err); end
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (ntt_data_o[k] !== '0) begin n_fail++; $display("FAIL reset_ntt_data[%0d] got %0d want 0", k, ntt_data_o[k]); end
    end
  endtask

  task automatic test_impulse();
    vec_t x, y, snap; bit [N-1:0] re, lasts; bit sinv, to; int acc, first, sb, rb;
    for (int k = 0; k < N; k++) x[k] = (k == 0) ? W'(1) : W'(0);
    send_frame(x, 1'b0, 1'b0, 1'b0, acc, re);
    collect_frame(0, y, lasts, first, sb, rb, snap, sinv, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL impulse_timeout got timeout want 8 beats"); end
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (y[k] !== W'(1)) begin n_fail++; $display("FAIL impulse_data[%0d] got %0d want 1", k, y[k]); end
    end
    n_tests++; if (lasts !== 8'h80) begin n_fail++; $display("FAIL impulse_last got %b want 10000000", lasts); end
    n_tests++; if (first - acc != PIPE_LAT + 2) begin n_fail++; $display("FAIL impulse_latency got %0d want %0d", first - acc, PIPE_LAT + 2); end
    n_tests++; if (rb != 0) begin n_fail++; $display("FAIL impulse_in_ready_busy got %0d cycles want 0", rb); end
    n_tests++; if (snap !== x || sinv !== 1'b0) begin n_fail++; $display("FAIL impulse_ntt_drive got inv %b want vector/inv 0", sinv); end
    n_tests++; if (sb != 0) begin n_fail++; $display("FAIL impulse_stability got %0d changes want 0", sb); end
  endtask

  task automatic test_all_ones();
    vec_t x, y, snap; bit [N-1:0] re, lasts; bit sinv, to; int acc, first, sb, rb;
    for (int k = 0; k < N; k++) x[k] = W'(1);
    send_frame(x, 1'b0, 1'b0, 1'b0, acc, re);
    collect_frame(0, y, lasts, first, sb, rb, snap, sinv, to);
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL ones_idle_after got busy %b in_ready %b want 0 1", busy, in_ready); end
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (y[k] !== ((k == 0) ? W'(N) : W'(0))) begin n_fail++; $display("FAIL ones_data[%0d] got %0d want %0d", k, y[k], (k == 0) ? N : 0); end
    end
  endtask

  task automatic test_inverse();
    vec_t x, y, snap; bit [N-1:0] re, lasts; bit sinv, to; int acc, first, sb, rb;
    logic [W-1:0] want;
`ifdef NTT_CTRL_INV_SCALE_EN
    want = W'(1);
`else
    want = W'(8);
`endif
    for (int k = 0; k < N; k++) x[k] = (k == 0) ? W'(8) : W'(0);
    send_frame(x, 1'b1, 1'b0, 1'b1, acc, re);
    collect_frame(0, y, lasts, first, sb, rb, snap, sinv, to);
    n_tests++; if (sinv !== 1'b1) begin n_fail++; $display("FAIL inverse_mode got %b want 1", sinv); end
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (y[k] !== want) begin n_fail++; $display("FAIL inverse_data[%0d] got %0d want %0d", k, y[k], want); end
    end
    n_tests++; if (first - acc != PIPE_LAT + 2) begin n_fail++; $display("FAIL inverse_latency got %0d want %0d", first - acc, PIPE_LAT + 2); end
  endtask

  task automatic test_backpressure();
    vec_t x, y, snap, exp_y; bit [N-1:0] re, lasts; bit sinv, to; int acc, first, sb, rb;
    for (int k = 0; k < N; k++) x[k] = W'($urandom_range(0, Q - 1));
    exp_y = expect_out(x, 1'b0);
    send_frame(x, 1'b0, 1'b0, 1'b0, acc, re);
    collect_frame(1, y, lasts, first, sb, rb, snap, sinv, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL bp_timeout got timeout want 8 beats"); end
    n_tests++; if (y !== exp_y) begin n_fail++; $display("FAIL bp_data got y[0]=%0d y[7]=%0d want %0d %0d", y[0], y[7], exp_y[0], exp_y[7]); end
    n_tests++; if (sb != 0) begin n_fail++; $display("FAIL bp_stability got %0d changes want 0", sb); end
    n_tests++; if (rb != 0) begin n_fail++; $display("FAIL bp_in_ready got %0d cycles high want 0", rb); end
    n_tests++; if (lasts !== 8'h80) begin n_fail++; $display("FAIL bp_last got %b want 10000000", lasts); end
  endtask

  task automatic test_range_gaps();
    vec_t x, y, snap, exp_y; bit [N-1:0] re, lasts; bit sinv, to; int acc, first, sb, rb;
    do_reset();
    for (int k = 0; k < N; k++) x[k] = W'($urandom_range(0, Q - 1));
    x[3] = W'(Q);
    exp_y = expect_out(x, 1'b0);
    send_frame(x, 1'b0, 1'b1, 1'b0, acc, re);
    n_tests++; if (re[2] !== 1'b0) begin n_fail++; $display("FAIL range_before got %b want 0", re[2]); end
    n_tests++; if (re[3] !== 1'b1) begin n_fail++; $display("FAIL range_rise got %b want 1", re[3]); end
    collect_frame(0, y, lasts, first, sb, rb, snap, sinv, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL range_count got timeout want 8 beats"); end
    n_tests++; if (range_err !== 1'b1) begin n_fail++; $display("FAIL range_sticky got %b want 1", range_err); end
    n_tests++; if (snap[3] !== W'(Q)) begin n_fail++; $display("FAIL range_stored got %0d want %0d", snap[3], Q); end
    n_tests++; if (y !== exp_y) begin n_fail++; $display("FAIL range_data got y[0]=%0d want %0d", y[0], exp_y[0]); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      vec_t x, y, snap, exp_y; bit [N-1:0] re, lasts; bit sinv, to, inv; int acc, first, sb, rb;
      inv = 1'($urandom);
      for (int k = 0; k < N; k++) x[k] = W'($urandom_range(0, Q - 1));
      exp_y = expect_out(x, inv);
      send_frame(x, inv, 1'($urandom), 1'b1, acc, re);
      collect_frame(2, y, lasts, first, sb, rb, snap, sinv, to);
      n_tests++; if (y !== exp_y || to) begin n_fail++; $display("FAIL rand%0d_data got y[1]=%0d want %0d (inv %b)", f, y[1], exp_y[1], inv); end
      n_tests++; if (snap !== x || sinv !== inv) begin n_fail++; $display("FAIL rand%0d_drive got inv %b want %b", f, sinv, inv); end
      n_tests++; if (sb != 0 || rb != 0 || lasts !== 8'h80) begin n_fail++; $display("FAIL rand%0d_flow got stab %0d rdy %0d last %b want 0 0 10000000", f, sb, rb, lasts); end
      n_tests++; if (first - acc != PIPE_LAT + 2) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", f, first - acc, PIPE_LAT + 2); end
    end
  endtask

  task automatic test_reset_mid_unload();
    vec_t x, y, snap; bit [N-1:0] re, lasts; bit sinv, to; int acc, first, sb, rb, beats = 0, budget = 0;
    for (int k = 0; k < N; k++) x[k] = (k == 0) ? W'(1) : ((k == 5) ? W'(20000) : W'(0));
    send_frame(x, 1'b0, 1'b0, 1'b0, acc, re);
    out_ready = 1'b1;
    while (beats < 3 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (out_valid) beats++;
    end
    @(negedge clk);
    n_tests++; if (range_err !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_pre got err %b busy %b valid %b want 1 1 1", range_err, busy, out_valid); end
    reset = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
    n_tests++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL abort_range_err got %b want 0", range_err); end
    for (int k = 0; k < N; k++) x[k] = (k == 0) ? W'(1) : W'(0);
    send_frame(x, 1'b0, 1'b0, 1'b0, acc, re);
    collect_frame(0, y, lasts, first, sb, rb, snap, sinv, to);
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (y[k] !== W'(1) || to) begin n_fail++; $display("FAIL abort_refill[%0d] got %0d want 1", k, y[k]); end
    end
  endtask

  initial begin
    for (longint g = 2; g < Q; g++) begin
      omega = mpow(g, (Q - 1) / N);
      if (mpow(omega, N / 2) == Q - 1) break;
    end
    omega_inv = mpow(omega, N - 1);
    test_reset();
    test_impulse();
    test_all_ones();
    test_inverse();
    test_backpressure();
    test_range_gaps();
    test_random();
    test_reset_mid_unload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want summary before time limit");
    $fatal(1, "watchdog");
  end

endmodule
